// File: rtl/ins_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : ins_mem_loader
// Purpose  : Receives a program as a big-endian byte stream and writes it,
//            one 32-bit word at a time, into instruction memory. Holds the
//            CPU core in reset for the duration of the load.
// Revision : 1.0 - initial release
// ============================================================================
module ins_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [15:0] count_q, count_d;
  logic [31:0] shift_q, shift_d;
  logic        byte_ready_q, byte_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] checksum_q, checksum_d;

  logic        too_big;
  logic        byte_take;

  assign too_big   = {16'd0, word_count} > MAX_WORDS;
  assign byte_take = byte_valid && byte_ready_q;

  // Next-state and next-output computation; status outputs follow the next state
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_idx_d  = word_idx_q;
    count_d     = count_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    checksum_d  = checksum_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count == 16'd0) begin
            // Empty program: nothing to load, complete immediately
            state_d    = S_DONE;
            err_d      = 1'b0;
            checksum_d = 32'd0;
          end else if (too_big) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d    = S_RECV;
            count_d    = word_count;
            checksum_d = 32'd0;
            err_d      = 1'b0;
            word_idx_d = 16'd0;
            byte_cnt_d = 2'd0;
          end
        end
      end
      S_RECV: begin
        if (byte_take) begin
          // Shifting left leaves the first byte in bits 31:24 after four bytes
          shift_d    = {shift_q[23:0], byte_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            mem_wdata_d = shift_d;
            checksum_d  = checksum_q ^ shift_d;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        if ((word_idx_q + 16'd1) == count_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RECV;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    byte_ready_d = (state_d == S_RECV);
    busy_d       = (state_d != S_IDLE);
    cpu_hold_d   = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      word_idx_q   <= 16'd0;
      count_q      <= 16'd0;
      shift_q      <= 32'd0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      cpu_hold_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      checksum_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      checksum_q   <= checksum_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign checksum   = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_ins_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_mem_loader
// Purpose  : Directed self-checking bench for ins_mem_loader. Two instances
//            share all inputs; the second uses a non-zero base address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] word_count;
  logic [7:0]  byte_data;
  logic        byte_valid;

  logic        byte_ready0, mem_we0, cpu_hold0, busy0, done0, err0;
  logic [31:0] mem_addr0, mem_wdata0, checksum0;
  logic        byte_ready1, mem_we1, cpu_hold1, busy1, done1, err1;
  logic [31:0] mem_addr1, mem_wdata1, checksum1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wa0[$];
  logic [31:0] wd0[$];
  logic [31:0] wa1[$];
  logic [31:0] wd1[$];
  int          done_cnt = 0;
  int          br_cnt   = 0;
  time         t_start;
  time         t_done;

  always #5 clk = ~clk;

  ins_mem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut0 (
    .CLK(clk), .RST(rst), .start(start), .word_count(word_count),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready0),
    .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .err(err0),
    .checksum(checksum0)
  );

  ins_mem_loader #(.BASE_ADDR(32'h0040_0000), .MAX_WORDS(256)) dut1 (
    .CLK(clk), .RST(rst), .start(start), .word_count(word_count),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .err(err1),
    .checksum(checksum1)
  );

  // Record memory writes and pulse activity away from the active edge
  always @(negedge clk) begin
    if (mem_we0) begin
      wa0.push_back(mem_addr0);
      wd0.push_back(mem_wdata0);
    end
    if (mem_we1) begin
      wa1.push_back(mem_addr1);
      wd1.push_back(mem_wdata1);
    end
    if (done0) done_cnt++;
    if (byte_ready0) br_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    done_cnt = 0;
    br_cnt   = 0;
  endtask

  task automatic do_start(input logic [15:0] wc);
    start      = 1'b1;
    word_count = wc;
    @(posedge clk);
    t_start = $time;
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard      = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready0 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("byte_ready_timeout", 32'd0, 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 100; i++) begin
      if (done0) break;
      tick();
    end
    if (i >= 100) check("done_timeout", 32'd0, 32'd1);
    t_done = $time - 1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; word_count = 16'd0; byte_data = 8'd0; byte_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // ---- reset state, both instances ----
    check("rst_byte_ready", {31'd0, byte_ready0}, 32'd0);
    check("rst_mem_we",     {31'd0, mem_we0},     32'd0);
    check("rst_cpu_hold",   {31'd0, cpu_hold0},   32'd0);
    check("rst_busy",       {31'd0, busy0},       32'd0);
    check("rst_done",       {31'd0, done0},       32'd0);
    check("rst_err",        {31'd0, err0},        32'd0);
    check("rst_mem_addr",   mem_addr0,            32'd0);
    check("rst_mem_wdata",  mem_wdata0,           32'd0);
    check("rst_checksum",   checksum0,            32'd0);
    check("rst1_flags", {26'd0, byte_ready1, mem_we1, cpu_hold1, busy1, done1, err1}, 32'd0);
    check("rst1_addr",      mem_addr1,            32'd0);
    check("rst1_data_csum", mem_wdata1 | checksum1, 32'd0);

    // ---- two-word load, no stalls ----
    clear_logs();
    do_start(16'd2);
    check("load_cpu_hold", {31'd0, cpu_hold0}, 32'd1);
    check("load_busy",     {31'd0, busy0},     32'd1);
    send_word(32'h2408_0005);
    send_word(32'h8C09_0000);
    wait_done();
    check("t1_latency", 32'((t_done - t_start) / 10), 32'd10);
    check("t1_hold_at_done", {31'd0, cpu_hold0}, 32'd1);
    tick();
    check("t1_hold_after", {31'd0, cpu_hold0}, 32'd0);
    check("t1_busy_after", {31'd0, busy0}, 32'd0);
    tick();
    check("t1_nwrites", 32'(wa0.size()), 32'd2);
    if (wa0.size() == 2) begin
      check("t1_addr0", wa0[0], 32'h0000_0000);
      check("t1_data0", wd0[0], 32'h2408_0005);
      check("t1_addr1", wa0[1], 32'h0000_0004);
      check("t1_data1", wd0[1], 32'h8C09_0000);
    end
    check("t1_checksum", checksum0, 32'hA801_0005);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_hold_wdata", mem_wdata0, 32'h8C09_0000);

    // ---- same load, 3-cycle stall between bytes 2 and 3 ----
    clear_logs();
    do_start(16'd2);
    send_byte(8'h24);
    send_byte(8'h08);
    tick(); tick(); tick();
    send_byte(8'h00);
    send_byte(8'h05);
    send_word(32'h8C09_0000);
    wait_done();
    check("t2_latency", 32'((t_done - t_start) / 10), 32'd13);
    tick(); tick();
    check("t2_nwrites", 32'(wa0.size()), 32'd2);
    if (wa0.size() == 2) begin
      check("t2_data0", wd0[0], 32'h2408_0005);
      check("t2_data1", wd0[1], 32'h8C09_0000);
    end
    check("t2_checksum", checksum0, 32'hA801_0005);

    // ---- word_count = 0 ----
    clear_logs();
    do_start(16'd0);
    check("z_done", {31'd0, done0}, 32'd1);
    check("z_err",  {31'd0, err0},  32'd0);
    tick(); tick();
    check("z_nwrites", 32'(wa0.size()), 32'd0);
    check("z_busy",    {31'd0, busy0},  32'd0);

    // ---- word_count = 257, rejected ----
    clear_logs();
    do_start(16'd257);
    check("big_done", {31'd0, done0}, 32'd1);
    check("big_err",  {31'd0, err0},  32'd1);
    tick();
    check("big_err_sticky", {31'd0, err0}, 32'd1);
    check("big_done_low",   {31'd0, done0}, 32'd0);
    tick(); tick();
    check("big_err_idle", {31'd0, err0}, 32'd1);
    check("big_nwrites", 32'(wa0.size()), 32'd0);
    check("big_byte_ready", 32'(br_cnt), 32'd0);

    // ---- start while busy is ignored; accepted start clears err ----
    clear_logs();
    do_start(16'd2);
    check("acc_err_clear", {31'd0, err0}, 32'd0);
    send_byte(8'hDE);
    send_byte(8'hAD);
    start = 1'b1; word_count = 16'd5;
    tick();
    start = 1'b0;
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_word(32'h0123_4567);
    wait_done();
    tick(); tick();
    for (int i = 0; i < 12; i++) tick();
    check("busy_nwrites", 32'(wa0.size()), 32'd2);
    check("busy_checksum", checksum0, 32'hDEAD_BEEF ^ 32'h0123_4567);
    check("busy_done_cnt", 32'(done_cnt), 32'd1);
    check("busy_idle", {31'd0, busy0}, 32'd0);

    // ---- RST mid-load after 6 bytes, then a fresh 1-word load ----
    clear_logs();
    do_start(16'd2);
    send_word(32'hAABB_CCDD);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_cpu_hold",   {31'd0, cpu_hold0},   32'd0);
    check("mr_byte_ready", {31'd0, byte_ready0}, 32'd0);
    check("mr_busy",       {31'd0, busy0},       32'd0);
    check("mr_nwrites", 32'(wa0.size()), 32'd1);
    clear_logs();
    do_start(16'd1);
    send_word(32'h1122_3344);
    wait_done();
    tick();
    check("mr2_nwrites", 32'(wa0.size()), 32'd1);
    if (wa0.size() == 1) begin
      check("mr2_addr", wa0[0], 32'h0000_0000);
      check("mr2_data", wd0[0], 32'h1122_3344);
    end
    check("mr2_checksum", checksum0, 32'h1122_3344);

    // ---- three words, both base addresses ----
    clear_logs();
    do_start(16'd3);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    send_word(32'h0000_0004);
    wait_done();
    tick();
    check("b_nwrites1", 32'(wa1.size()), 32'd3);
    if (wa1.size() == 3) begin
      check("b_addr1_0", wa1[0], 32'h0040_0000);
      check("b_addr1_1", wa1[1], 32'h0040_0004);
      check("b_addr1_2", wa1[2], 32'h0040_0008);
      check("b_data1_2", wd1[2], 32'h0000_0004);
    end
    if (wa0.size() == 3) begin
      check("b_addr0_2", wa0[2], 32'h0000_0008);
    end else begin
      check("b_nwrites0", 32'(wa0.size()), 32'd3);
    end
    check("b_checksum1", checksum1, 32'h0000_0007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
